rvv_backend_dispatch_opcollect: RTL and testbench

- Parametrised operand collector between the uop queue and the reservation stations.
- Buffers up to DEPTH uops in order and allocates NUM_RD_PORT VRF read ports across their pending vs1/vs2/vd requests, oldest first. Requests to the same register in one cycle share a port.
- Operands are gathered over as many cycles as needed. Complete uops retire in order through a per-lane valid/ready interface, up to NUM_UOP per cycle.

---
 rtl/rvv_backend_dispatch_pkg.sv | 36 +++
 rtl/rvv_backend_opcollect_alloc.sv | 50 +++++
 rtl/rvv_backend_dispatch_opcollect.sv | 162 ++++++++++++++++
 tb/tb_rvv_backend_dispatch_opcollect.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_dispatch_pkg.sv
// Shared types and helpers for the dispatch-stage operand collector.
// The NUM_* defaults follow the dispatch width macros when those are defined elsewhere.
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif
`ifndef NUM_DP_VRF
`define NUM_DP_VRF 4
`endif

package rvv_backend_dispatch_pkg;

  localparam int NUM_DP_UOP_DEF = `NUM_DP_UOP;
  localparam int NUM_DP_VRF_DEF = `NUM_DP_VRF;
  localparam int NUM_OPN        = 3;

  typedef enum logic [1:0] {
    VS1 = 2'd0,
    VS2 = 2'd1,
    VD  = 2'd2
  } OPN_SEL_e;

  // Bit order of need/got follows OPN_SEL_e: [0]=vs1, [1]=vs2, [2]=vd.
  typedef struct packed {
    logic [NUM_OPN-1:0] need;
    logic [NUM_OPN-1:0] got;
  } COLLECT_ENTRY_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_wrap(input int p, input int depth);
    return p % depth;
  endfunction

endpackage

// File: rtl/rvv_backend_opcollect_alloc.sv
// Combinational VRF read-port allocator: walks requests in age order, shares a port
// between requests for the same register, and stops once every port is taken.
module rvv_backend_opcollect_alloc
  import rvv_backend_dispatch_pkg::*;
#(
  parameter int NUM_REQ     = 12,
  parameter int NUM_RD_PORT = 4,
  parameter int REGIDX_W    = 5,
  localparam int PSEL_W     = clog2_min1(NUM_RD_PORT)
) (
  input  logic [NUM_REQ-1:0]                    req_vld,
  input  logic [NUM_REQ-1:0][REGIDX_W-1:0]      req_idx,
  output logic [NUM_RD_PORT-1:0]                rd_en,
  output logic [NUM_RD_PORT-1:0][REGIDX_W-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]                    req_served,
  output logic [NUM_REQ-1:0][PSEL_W-1:0]        req_port
);

  int   used;
  logic hit;

  always_comb begin
    rd_en      = '0;
    rd_addr    = '0;
    req_served = '0;
    req_port   = '0;
    used       = 0;
    hit        = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req_vld[r] && (used < NUM_RD_PORT)) begin
        hit = 1'b0;
        for (int p = 0; p < NUM_RD_PORT; p++) begin
          if (!hit && rd_en[p] && (rd_addr[p] == req_idx[r])) begin
            hit           = 1'b1;
            req_served[r] = 1'b1;
            req_port[r]   = PSEL_W'(p);
          end
        end
        if (!hit) begin
          rd_en[used]   = 1'b1;
          rd_addr[used] = req_idx[r];
          req_served[r] = 1'b1;
          req_port[r]   = PSEL_W'(used);
          used          = used + 1;
        end
      end
    end
  end

endmodule

// File: rtl/rvv_backend_dispatch_opcollect.sv
// In-order operand collector: buffers dispatched uops, gathers vs1/vs2/vd from the VRF
// over as many cycles as the read ports allow, and retires complete uops from the head.
module rvv_backend_dispatch_opcollect
  import rvv_backend_dispatch_pkg::*;
#(
  parameter int NUM_UOP     = NUM_DP_UOP_DEF,
  parameter int NUM_RD_PORT = NUM_DP_VRF_DEF,
  parameter int DEPTH       = 4,
  parameter int VLEN        = 128,
  parameter int REGIDX_W    = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [NUM_UOP-1:0]                    uop_valid,
  output logic [NUM_UOP-1:0]                    uop_ready,
  input  logic [NUM_UOP-1:0][2:0]               uop_need,
  input  logic [NUM_UOP-1:0][2:0][REGIDX_W-1:0] uop_idx,
  output logic [NUM_RD_PORT-1:0]                rd_en,
  output logic [NUM_RD_PORT-1:0][REGIDX_W-1:0]  rd_addr,
  input  logic [NUM_RD_PORT-1:0][VLEN-1:0]      rd_data,
  input  logic [VLEN-1:0]                       v0_mask,
  output logic [NUM_UOP-1:0]                    opn_valid,
  input  logic [NUM_UOP-1:0]                    opn_ready,
  output logic [NUM_UOP-1:0][VLEN-1:0]          opn_vs1,
  output logic [NUM_UOP-1:0][VLEN-1:0]          opn_vs2,
  output logic [NUM_UOP-1:0][VLEN-1:0]          opn_vd,
  output logic [NUM_UOP-1:0][VLEN-1:0]          opn_v0
);

  localparam int PTR_W   = clog2_min1(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int NUM_REQ = DEPTH * NUM_OPN;
  localparam int PSEL_W  = clog2_min1(NUM_RD_PORT);

  COLLECT_ENTRY_t                     entry_reg [DEPTH];
  logic [NUM_OPN-1:0][REGIDX_W-1:0]   idx_reg   [DEPTH];
  logic [NUM_OPN-1:0][VLEN-1:0]       opn_reg   [DEPTH];
  logic [VLEN-1:0]                    v0_reg    [DEPTH];
  logic [PTR_W-1:0]                   head_reg, tail_reg;
  logic [CNT_W-1:0]                   count_reg;

  logic [CNT_W-1:0]                   free_cnt, enq_num, deq_num;
  logic [NUM_UOP-1:0]                 enq_acc, deq_acc;
  logic [DEPTH-1:0]                   age_cmpl;
  logic [PTR_W-1:0]                   age_ptr   [DEPTH];
  logic [NUM_REQ-1:0]                 req_vld, req_served;
  logic [NUM_REQ-1:0][REGIDX_W-1:0]   req_idx;
  logic [NUM_REQ-1:0][PSEL_W-1:0]     req_port;

  assign free_cnt = CNT_W'(DEPTH) - count_reg;

  // Age-ordered view of the FIFO; only entries already resident at the start of the
  // cycle can raise read requests, so same-cycle enqueues are never allocated.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_ptr[gi]  = head_reg + PTR_W'(gi);
      assign age_cmpl[gi] = (entry_reg[age_ptr[gi]].got == entry_reg[age_ptr[gi]].need);
      for (genvar gj = 0; gj < NUM_OPN; gj++) begin : g_opn
        assign req_vld[gi*NUM_OPN+gj] = (CNT_W'(gi) < count_reg)
                                      && entry_reg[age_ptr[gi]].need[gj]
                                      && !entry_reg[age_ptr[gi]].got[gj];
        assign req_idx[gi*NUM_OPN+gj] = idx_reg[age_ptr[gi]][gj];
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_UOP; gi++) begin : g_lane
      assign uop_ready[gi] = (free_cnt > CNT_W'(gi));
      assign enq_acc[gi]   = (&uop_valid[gi:0]) && uop_ready[gi];
      assign opn_valid[gi] = (CNT_W'(gi) < count_reg) && (&age_cmpl[gi:0]);
      assign deq_acc[gi]   = (&opn_valid[gi:0]) && (&opn_ready[gi:0]);
      // Operands that were never requested, or belong to an incomplete slot, read as 0.
      assign opn_vs1[gi] = (opn_valid[gi] && entry_reg[age_ptr[gi]].need[VS1])
                         ? opn_reg[age_ptr[gi]][VS1] : '0;
      assign opn_vs2[gi] = (opn_valid[gi] && entry_reg[age_ptr[gi]].need[VS2])
                         ? opn_reg[age_ptr[gi]][VS2] : '0;
      assign opn_vd[gi]  = (opn_valid[gi] && entry_reg[age_ptr[gi]].need[VD])
                         ? opn_reg[age_ptr[gi]][VD] : '0;
      assign opn_v0[gi]  = opn_valid[gi] ? v0_reg[age_ptr[gi]] : '0;
    end
  endgenerate

  always_comb begin
    enq_num = '0;
    deq_num = '0;
    for (int i = 0; i < NUM_UOP; i++) begin
      enq_num = enq_num + CNT_W'(enq_acc[i]);
      deq_num = deq_num + CNT_W'(deq_acc[i]);
    end
  end

  rvv_backend_opcollect_alloc #(
    .NUM_REQ     (NUM_REQ),
    .NUM_RD_PORT (NUM_RD_PORT),
    .REGIDX_W    (REGIDX_W)
  ) u_alloc (
    .req_vld    (req_vld),
    .req_idx    (req_idx),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .req_served (req_served),
    .req_port   (req_port)
  );

  // Retiring entries are complete and thus never served, and enqueues land only in free
  // slots, so capture, retire and enqueue never touch the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        entry_reg[e] <= '0;
      end
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        entry_reg[e].got <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        for (int o = 0; o < NUM_OPN; o++) begin
          if (req_served[k*NUM_OPN+o]) begin
            entry_reg[age_ptr[k]].got[o] <= 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_UOP; i++) begin
        if (enq_acc[i]) begin
          entry_reg[tail_reg + PTR_W'(i)] <= '{need: uop_need[i], got: '0};
        end
      end
      head_reg  <= head_reg + PTR_W'(deq_num);
      tail_reg  <= tail_reg + PTR_W'(enq_num);
      count_reg <= count_reg + enq_num - deq_num;
    end
  end

  // Payload storage needs no reset: it is only observed through need/got/opn_valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        for (int o = 0; o < NUM_OPN; o++) begin
          if (req_served[k*NUM_OPN+o]) begin
            opn_reg[age_ptr[k]][o] <= rd_data[req_port[k*NUM_OPN+o]];
          end
        end
      end
      for (int i = 0; i < NUM_UOP; i++) begin
        if (enq_acc[i]) begin
          idx_reg[tail_reg + PTR_W'(i)] <= uop_idx[i];
          v0_reg[tail_reg + PTR_W'(i)]  <= v0_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_dispatch_opcollect.sv
// Self-checking bench for the operand collector: directed scenarios plus random traffic
// checked against a queue-based model of the collector's behaviour.
module tb_rvv_backend_dispatch_opcollect;

  localparam int NUM_UOP     = 2;
  localparam int NUM_RD_PORT = 4;
  localparam int DEPTH       = 4;
  localparam int VLEN        = 128;
  localparam int REGIDX_W    = 5;

  logic                                  clk = 1'b0;
  logic                                  rst_n = 1'b0;
  logic                                  flush = 1'b0;
  logic [NUM_UOP-1:0]                    uop_valid = '0;
  logic [NUM_UOP-1:0]                    uop_ready;
  logic [NUM_UOP-1:0][2:0]               uop_need = '0;
  logic [NUM_UOP-1:0][2:0][REGIDX_W-1:0] uop_idx = '0;
  logic [NUM_RD_PORT-1:0]                rd_en;
  logic [NUM_RD_PORT-1:0][REGIDX_W-1:0]  rd_addr;
  logic [NUM_RD_PORT-1:0][VLEN-1:0]      rd_data;
  logic [VLEN-1:0]                       v0_mask = '0;
  logic [NUM_UOP-1:0]                    opn_valid;
  logic [NUM_UOP-1:0]                    opn_ready = '0;
  logic [NUM_UOP-1:0][VLEN-1:0]          opn_vs1, opn_vs2, opn_vd, opn_v0;

  logic [VLEN-1:0] vrf [32];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // The VRF answers in the same cycle as the address.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORT; p++) rd_data[p] = vrf[rd_addr[p]];
  end

  rvv_backend_dispatch_opcollect #(
    .NUM_UOP(NUM_UOP), .NUM_RD_PORT(NUM_RD_PORT), .DEPTH(DEPTH),
    .VLEN(VLEN), .REGIDX_W(REGIDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_need(uop_need), .uop_idx(uop_idx),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .v0_mask(v0_mask),
    .opn_valid(opn_valid), .opn_ready(opn_ready),
    .opn_vs1(opn_vs1), .opn_vs2(opn_vs2), .opn_vd(opn_vd), .opn_v0(opn_v0)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]                need;
    logic [2:0]                got;
    logic [2:0][REGIDX_W-1:0]  idx;
    logic [2:0][VLEN-1:0]      data;
    logic [VLEN-1:0]           v0;
  } muop_t;

  muop_t mq[$];
  int    exp_ports[$];
  int    srv_e[$];
  int    srv_o[$];
  logic [NUM_UOP-1:0]                   exp_ready, exp_valid;
  logic [NUM_RD_PORT-1:0]               exp_rd_en;
  logic [NUM_RD_PORT-1:0][REGIDX_W-1:0] exp_rd_addr;

  function automatic void model_eval();
    int ok;
    int full;
    int hit;
    exp_ports.delete();
    srv_e.delete();
    srv_o.delete();
    ok = 1;
    for (int i = 0; i < NUM_UOP; i++) begin
      exp_ready[i] = ((DEPTH - mq.size()) > i);
      if (i >= mq.size()) ok = 0;
      else if (mq[i].got != mq[i].need) ok = 0;
      exp_valid[i] = (ok != 0);
    end
    full = 0;
    for (int e = 0; e < mq.size(); e++) begin
      for (int o = 0; o < 3; o++) begin
        if (full == 0 && mq[e].need[o] && !mq[e].got[o]) begin
          if (exp_ports.size() == NUM_RD_PORT) full = 1;
          else begin
            hit = 0;
            foreach (exp_ports[p]) if (exp_ports[p] == int'(mq[e].idx[o])) hit = 1;
            if (hit == 0) exp_ports.push_back(int'(mq[e].idx[o]));
            srv_e.push_back(e);
            srv_o.push_back(o);
          end
        end
      end
    end
    exp_rd_en   = '0;
    exp_rd_addr = '0;
    foreach (exp_ports[p]) begin
      exp_rd_en[p]   = 1'b1;
      exp_rd_addr[p] = REGIDX_W'(exp_ports[p]);
    end
  endfunction

  function automatic void model_tick();
    int    nenq;
    int    ndeq;
    int    sz;
    muop_t u;
    if (flush) begin
      mq.delete();
      return;
    end
    foreach (srv_e[k]) begin
      u = mq[srv_e[k]];
      u.got[srv_o[k]]  = 1'b1;
      u.data[srv_o[k]] = vrf[u.idx[srv_o[k]]];
      mq[srv_e[k]] = u;
    end
    sz = mq.size();
    nenq = 0;
    ndeq = 0;
    for (int i = 0; i < NUM_UOP; i++) begin
      if (nenq == i && uop_valid[i] && (DEPTH - sz) > i) nenq++;
      if (ndeq == i && exp_valid[i] && opn_ready[i]) ndeq++;
    end
    repeat (ndeq) void'(mq.pop_front());
    for (int i = 0; i < nenq; i++) begin
      u.need = uop_need[i];
      u.got  = '0;
      u.idx  = uop_idx[i];
      u.data = '0;
      u.v0   = v0_mask;
      mq.push_back(u);
    end
  endfunction

  // Advance model and DUT by one clock; inputs are driven 1 time unit after posedge.
  task automatic tick();
    model_eval();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    uop_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic drive_lane(input int i, input logic [2:0] need, input int a1, input int a2,
                            input int a3);
    uop_valid[i]  = 1'b1;
    uop_need[i]   = need;
    uop_idx[i][0] = REGIDX_W'(a1);
    uop_idx[i][1] = REGIDX_W'(a2);
    uop_idx[i][2] = REGIDX_W'(a3);
  endtask

  task automatic drain();
    int n;
    idle();
    opn_ready = '1;
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (mq.size() != 0 || opn_valid !== '0 || uop_ready !== 2'b11) begin
      mismatched++;
      $display("FAIL drain: opn_valid=%b uop_ready=%b model_left=%0d want 00/11/0",
               opn_valid, uop_ready, mq.size());
    end
    opn_ready = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    compared++;
    if (uop_ready !== 2'b11) begin
      mismatched++; $display("FAIL reset_ready: got %b want 11", uop_ready);
    end
    compared++;
    if (opn_valid !== 2'b00) begin
      mismatched++; $display("FAIL reset_valid: got %b want 00", opn_valid);
    end
    compared++;
    if (rd_en !== '0 || rd_addr !== '0) begin
      mismatched++; $display("FAIL reset_rd: rd_en=%b rd_addr=%h want 0/0", rd_en, rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_read();
    idle();
    opn_ready = '0;
    v0_mask = {4{$urandom}};
    drive_lane(0, 3'b111, 1, 2, 3);
    drive_lane(1, 3'b111, 4, 5, 6);
    tick();
    idle();
    compared++;
    if (rd_en !== 4'b1111 || rd_addr !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
      mismatched++; $display("FAIL basic_t1_rd: rd_en=%b rd_addr=%h want 1111/%h", rd_en,
                             rd_addr, {5'd4, 5'd3, 5'd2, 5'd1});
    end
    compared++;
    if (opn_valid !== 2'b00) begin
      mismatched++; $display("FAIL basic_t1_valid: got %b want 00", opn_valid);
    end
    tick();
    compared++;
    if (opn_valid !== 2'b01 || rd_en !== 4'b0011 || rd_addr !== {5'd0, 5'd0, 5'd6, 5'd5}) begin
      mismatched++; $display("FAIL basic_t2: valid=%b rd_en=%b rd_addr=%h want 01/0011/%h",
                             opn_valid, rd_en, rd_addr, {5'd0, 5'd0, 5'd6, 5'd5});
    end
    compared++;
    if (opn_vs1[0] !== vrf[1] || opn_vs2[0] !== vrf[2] || opn_vd[0] !== vrf[3]
        || opn_v0[0] !== v0_mask) begin
      mismatched++; $display("FAIL basic_t2_data0: vs1=%h want %h", opn_vs1[0], vrf[1]);
    end
    tick();
    compared++;
    if (opn_valid !== 2'b11) begin
      mismatched++; $display("FAIL basic_t3_valid: got %b want 11", opn_valid);
    end
    compared++;
    if (opn_vs1[1] !== vrf[4] || opn_vs2[1] !== vrf[5] || opn_vd[1] !== vrf[6]) begin
      mismatched++; $display("FAIL basic_t3_data1: vd=%h want %h", opn_vd[1], vrf[6]);
    end
    drain();
  endtask

  task automatic test_dedup();
    idle();
    drive_lane(0, 3'b011, 7, 7, 0);
    drive_lane(1, 3'b001, 7, 0, 0);
    tick();
    idle();
    compared++;
    if (rd_en !== 4'b0001 || rd_addr !== {5'd0, 5'd0, 5'd0, 5'd7}) begin
      mismatched++; $display("FAIL dedup_rd: rd_en=%b rd_addr=%h want 0001/%h", rd_en,
                             rd_addr, {5'd0, 5'd0, 5'd0, 5'd7});
    end
    tick();
    compared++;
    if (opn_valid !== 2'b11) begin
      mismatched++; $display("FAIL dedup_valid: got %b want 11", opn_valid);
    end
    compared++;
    if (opn_vs1[0] !== vrf[7] || opn_vs2[0] !== vrf[7] || opn_vs1[1] !== vrf[7]
        || opn_vd[0] !== '0) begin
      mismatched++; $display("FAIL dedup_data: vs1_0=%h vs2_0=%h vs1_1=%h want %h (vd 0)",
                             opn_vs1[0], opn_vs2[0], opn_vs1[1], vrf[7]);
    end
    drain();
  endtask

  task automatic test_scalar();
    idle();
    drive_lane(0, 3'b000, 9, 9, 9);
    tick();
    idle();
    compared++;
    if (opn_valid !== 2'b01 || rd_en !== '0) begin
      mismatched++; $display("FAIL scalar: valid=%b rd_en=%b want 01/0000", opn_valid, rd_en);
    end
    drain();
  endtask

  task automatic test_full_backpressure();
    idle();
    opn_ready = '0;
    drive_lane(0, 3'b000, 0, 0, 0);
    drive_lane(1, 3'b000, 0, 0, 0);
    tick();
    compared++;
    if (uop_ready !== 2'b11) begin
      mismatched++; $display("FAIL full_half_ready: got %b want 11", uop_ready);
    end
    tick();
    idle();
    drive_lane(0, 3'b000, 0, 0, 0);
    compared++;
    if (uop_ready !== 2'b00 || opn_valid !== 2'b11) begin
      mismatched++; $display("FAIL full_ready: ready=%b valid=%b want 00/11", uop_ready,
                             opn_valid);
    end
    tick();
    opn_ready = 2'b01;
    compared++;
    if (uop_ready !== 2'b00) begin
      mismatched++; $display("FAIL full_no_accept: got %b want 00", uop_ready);
    end
    tick();
    opn_ready = 2'b00;
    compared++;
    if (uop_ready !== 2'b01 || opn_valid !== 2'b11) begin
      mismatched++; $display("FAIL full_one_retire: ready=%b valid=%b want 01/11", uop_ready,
                             opn_valid);
    end
    tick();
    idle();
    compared++;
    if (uop_ready !== 2'b00) begin
      mismatched++; $display("FAIL full_refill: got %b want 00", uop_ready);
    end
    drain();
  endtask

  task automatic test_in_order();
    idle();
    opn_ready = '0;
    drive_lane(0, 3'b111, 8, 9, 10);
    drive_lane(1, 3'b000, 0, 0, 0);
    tick();
    idle();
    compared++;
    if (opn_valid !== 2'b00 || rd_en !== 4'b0111) begin
      mismatched++; $display("FAIL inorder_wait: valid=%b rd_en=%b want 00/0111", opn_valid,
                             rd_en);
    end
    tick();
    compared++;
    if (opn_valid !== 2'b11 || opn_vd[0] !== vrf[10]) begin
      mismatched++; $display("FAIL inorder_done: valid=%b vd=%h want 11/%h", opn_valid,
                             opn_vd[0], vrf[10]);
    end
    drain();
  endtask

  task automatic test_flush();
    idle();
    opn_ready = '0;
    drive_lane(0, 3'b111, 11, 12, 13);
    drive_lane(1, 3'b111, 14, 15, 16);
    tick();
    idle();
    drive_lane(0, 3'b111, 17, 18, 19);
    tick();
    idle();
    compared++;
    if (opn_valid !== 2'b01) begin
      mismatched++; $display("FAIL flush_pre: got %b want 01", opn_valid);
    end
    flush = 1'b1;
    drive_lane(0, 3'b000, 0, 0, 0);
    drive_lane(1, 3'b000, 0, 0, 0);
    tick();
    idle();
    compared++;
    if (opn_valid !== 2'b00 || uop_ready !== 2'b11 || rd_en !== '0) begin
      mismatched++; $display("FAIL flush_post: valid=%b ready=%b rd_en=%b want 00/11/0000",
                             opn_valid, uop_ready, rd_en);
    end
    drive_lane(0, 3'b000, 0, 0, 0);
    tick();
    idle();
    compared++;
    if (opn_valid !== 2'b01) begin
      mismatched++; $display("FAIL flush_restart: got %b want 01", opn_valid);
    end
    drain();
  endtask

  task automatic test_async_reset();
    idle();
    opn_ready = '0;
    drive_lane(0, 3'b111, 20, 21, 22);
    drive_lane(1, 3'b000, 0, 0, 0);
    tick();
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (opn_valid !== 2'b00 || rd_en !== '0 || rd_addr !== '0 || uop_ready !== 2'b11) begin
      mismatched++; $display("FAIL async_reset: valid=%b rd_en=%b rd_addr=%h ready=%b",
                             opn_valid, rd_en, rd_addr, uop_ready);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (opn_valid !== 2'b00 || rd_en !== '0) begin
      mismatched++; $display("FAIL async_release: valid=%b rd_en=%b want 00/0000", opn_valid,
                             rd_en);
    end
  endtask

  task automatic test_random();
    logic [4*VLEN-1:0] exp_d;
    logic [4*VLEN-1:0] got_d;
    for (int c = 0; c < 400; c++) begin
      uop_valid = NUM_UOP'($urandom_range(0, 3));
      for (int i = 0; i < NUM_UOP; i++) begin
        uop_need[i] = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom);
        for (int o = 0; o < 3; o++) uop_idx[i][o] = REGIDX_W'($urandom_range(0, 7));
      end
      v0_mask   = {4{$urandom}};
      opn_ready = ($urandom_range(0, 3) == 0) ? NUM_UOP'($urandom) : '1;
      flush     = ($urandom_range(0, 49) == 0);
      model_eval();
      compared++;
      if (uop_ready !== exp_ready || opn_valid !== exp_valid) begin
        mismatched++; $display("FAIL rand_hs c%0d: ready=%b/%b valid=%b/%b (got/want)", c,
                               uop_ready, exp_ready, opn_valid, exp_valid);
      end
      compared++;
      if (rd_en !== exp_rd_en || rd_addr !== exp_rd_addr) begin
        mismatched++; $display("FAIL rand_rd c%0d: rd_en=%b want %b rd_addr=%h want %h", c,
                               rd_en, exp_rd_en, rd_addr, exp_rd_addr);
      end
      for (int i = 0; i < NUM_UOP; i++) begin
        if (exp_valid[i]) begin
          exp_d = {mq[i].need[2] ? mq[i].data[2] : '0, mq[i].need[1] ? mq[i].data[1] : '0,
                   mq[i].need[0] ? mq[i].data[0] : '0, mq[i].v0};
          got_d = {opn_vd[i], opn_vs2[i], opn_vs1[i], opn_v0[i]};
          compared++;
          if (got_d !== exp_d) begin
            mismatched++; $display("FAIL rand_data c%0d lane%0d: got %h want %h", c, i,
                                   got_d[4*VLEN-1:2*VLEN], exp_d[4*VLEN-1:2*VLEN]);
          end
        end
      end
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) vrf[r] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_basic_read();
    test_dedup();
    test_scalar();
    test_full_backpressure();
    test_in_order();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
